// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car path: floor width, default floor count,
// controller state encoding and a floor-to-one-hot helper also used by the request register.
package elevator_pkg;

   localparam int FLOOR_W            = 4;
   localparam int DEFAULT_NUM_FLOORS = 10;
   localparam int TIMER_W            = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVING    = 2'd1,
      ARRIVE    = 2'd2,
      DOOR_OPEN = 2'd3
   } elev_state_e;

   // Floor numbers are 1-based; bit 0 of the result is floor 1.
   function automatic logic [0:DEFAULT_NUM_FLOORS-1] floor_onehot(input logic [FLOOR_W-1:0] floor);
      logic [0:DEFAULT_NUM_FLOORS-1] oh;
      oh = '0;
      for (int i = 0; i < DEFAULT_NUM_FLOORS; i++) begin
         oh[i] = (floor == FLOOR_W'(i + 1));
      end
      return oh;
   endfunction

endpackage

// File: rtl/elevator_car_controller_if.sv
// Bus between the floor selection logic (master) and the car controller (slave).
interface elevator_car_controller_if
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
) ();

   logic [FLOOR_W-1:0]    target;
   logic                  target_valid;
   logic [FLOOR_W-1:0]    location;
   logic                  moving_up;
   logic                  moving_down;
   logic                  door_open;
   logic [0:NUM_FLOORS-1] clear_req;
   logic                  busy;

   modport master (
      output target, target_valid,
      input  location, moving_up, moving_down, door_open, clear_req, busy
   );

   modport slave (
      input  target, target_valid,
      output location, moving_up, moving_down, door_open, clear_req, busy
   );

endinterface

// File: rtl/elevator_dwell_timer.sv
// Loadable down-counter: load has priority, enable decrements and the count saturates at zero;
// done is high whenever the count is zero.
module elevator_dwell_timer
   import elevator_pkg::*;
#(
   parameter int CNT_W = TIMER_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Elevator car controller: moves the car one floor at a time to the selected floor, pulses
// clear_req on arrival and times the door. Define ELEVATOR_ESTOP_EN to add the estop stall input.
module elevator_car_controller
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = DEFAULT_NUM_FLOORS,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 16,
   parameter int HOME_FLOOR    = 1
) (
   input logic clk,
   input logic rst_n,
`ifdef ELEVATOR_ESTOP_EN
   input logic estop,
`endif
   elevator_car_controller_if.slave bus
);

   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS);
   localparam logic [FLOOR_W-1:0] BOT_FLOOR   = FLOOR_W'(1);
   localparam logic [FLOOR_W-1:0] HOME        = FLOOR_W'(HOME_FLOOR);
   localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

   elev_state_e           r_state, w_state_next;
   logic [FLOOR_W-1:0]    r_location, w_location_next;
   logic [FLOOR_W-1:0]    r_dest, w_dest_next;
   logic                  r_dir, w_dir_next;
   logic                  r_moving_up, r_moving_down, r_door_open, r_busy;
   logic [0:NUM_FLOORS-1] r_clear_req, w_clear_next;
   logic                  w_stall, w_target_ok;
   logic                  w_travel_load, w_travel_en, w_travel_done;
   logic                  w_door_load, w_door_en, w_door_done;

`ifdef ELEVATOR_ESTOP_EN
   assign w_stall = estop;
`else
   assign w_stall = 1'b0;
`endif

   assign w_target_ok = bus.target_valid && !w_stall &&
                        (bus.target >= BOT_FLOOR) && (bus.target <= TOP_FLOOR);

   elevator_dwell_timer #(.CNT_W(TIMER_W)) u_travel_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_travel_load),
      .i_load_val (TRAVEL_LOAD),
      .i_en       (w_travel_en),
      .o_done     (w_travel_done)
   );

   elevator_dwell_timer #(.CNT_W(TIMER_W)) u_door_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_door_load),
      .i_load_val (DOOR_LOAD),
      .i_en       (w_door_en),
      .o_done     (w_door_done)
   );

   always_comb begin
      w_state_next    = r_state;
      w_location_next = r_location;
      w_dest_next     = r_dest;
      w_dir_next      = r_dir;
      w_travel_load   = 1'b0;
      w_travel_en     = 1'b0;
      w_door_load     = 1'b0;
      w_door_en       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_target_ok) begin
               if (bus.target == r_location) begin
                  w_state_next = ARRIVE;
               end else begin
                  w_dest_next   = bus.target;
                  w_dir_next    = (bus.target > r_location);
                  w_travel_load = 1'b1;
                  w_state_next  = MOVING;
               end
            end
         end
         MOVING: begin
            // A stalled trip holds the counter, location and destination untouched.
            if (!w_stall) begin
               if (w_travel_done) begin
                  if (r_dir && (r_location < TOP_FLOOR)) begin
                     w_location_next = r_location + 1'b1;
                  end else if (!r_dir && (r_location > BOT_FLOOR)) begin
                     w_location_next = r_location - 1'b1;
                  end
                  if (w_location_next == r_dest) begin
                     w_state_next = ARRIVE;
                  end else begin
                     w_travel_load = 1'b1;
                  end
               end else begin
                  w_travel_en = 1'b1;
               end
            end
         end
         ARRIVE: begin
            w_door_load  = 1'b1;
            w_state_next = DOOR_OPEN;
         end
         DOOR_OPEN: begin
            if (!w_stall) begin
               if (w_door_done) begin
                  w_state_next = IDLE;
               end else begin
                  w_door_en = 1'b1;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_clear
         assign w_clear_next[gi] = (w_state_next == ARRIVE) && (w_location_next == FLOOR_W'(gi + 1));
      end
   endgenerate

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_location    <= HOME;
         r_dest        <= HOME;
         r_dir         <= 1'b0;
         r_moving_up   <= 1'b0;
         r_moving_down <= 1'b0;
         r_door_open   <= 1'b0;
         r_busy        <= 1'b0;
         r_clear_req   <= '0;
      end else begin
         r_state       <= w_state_next;
         r_location    <= w_location_next;
         r_dest        <= w_dest_next;
         r_dir         <= w_dir_next;
         r_moving_up   <= (w_state_next == MOVING) && w_dir_next && !w_stall;
         r_moving_down <= (w_state_next == MOVING) && !w_dir_next && !w_stall;
         r_door_open   <= (w_state_next == DOOR_OPEN);
         r_busy        <= (w_state_next != IDLE);
         r_clear_req   <= w_clear_next;
      end
   end

   assign bus.location    = r_location;
   assign bus.moving_up   = r_moving_up;
   assign bus.moving_down = r_moving_down;
   assign bus.door_open   = r_door_open;
   assign bus.clear_req   = r_clear_req;
   assign bus.busy        = r_busy;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Scoreboard bench for elevator_car_controller: expected events are queued as trips are requested
// and compared against events the monitor extracts from the DUT outputs.
module tb_elevator_car_controller;
   import elevator_pkg::*;

   localparam int NF     = 10;
   localparam int TRAVEL = 8;
   localparam int DOOR   = 16;
   localparam int EV_LOC = 0, EV_UP = 1, EV_DOWN = 2, EV_CLR = 3, EV_DOOR = 4;

   typedef struct {
      int kind;
      int val;
      int t;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic estop = 1'b0;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   int   model_loc = 1;
   bit   inv_bad  = 1'b0;
   ev_t  exp_q[$];
   ev_t  obs_q[$];

   elevator_car_controller_if #(.NUM_FLOORS(NF)) bus ();

   elevator_car_controller #(
      .NUM_FLOORS    (NF),
      .TRAVEL_CYCLES (TRAVEL),
      .DOOR_CYCLES   (DOOR),
      .HOME_FLOOR    (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef ELEVATOR_ESTOP_EN
      .estop (estop),
`endif
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: location changes, run lengths of moving/door, clear pulses, invariants.
   initial begin
      logic [FLOOR_W-1:0] prev_loc;
      logic [0:NF-1]      clr_v;
      int up_len, dn_len, door_len;
      prev_loc = 'x;
      up_len = 0; dn_len = 0; door_len = 0;
      forever begin
         @(negedge clk);
         clr_v = bus.clear_req;
         if (bus.location !== prev_loc) obs_q.push_back(ev_t'{EV_LOC, int'(bus.location), cyc});
         prev_loc = bus.location;
         if (bus.moving_up === 1'b1) up_len++;
         else if (up_len > 0) begin obs_q.push_back(ev_t'{EV_UP, up_len, cyc}); up_len = 0; end
         if (bus.moving_down === 1'b1) dn_len++;
         else if (dn_len > 0) begin obs_q.push_back(ev_t'{EV_DOWN, dn_len, cyc}); dn_len = 0; end
         if (clr_v !== '0) obs_q.push_back(ev_t'{EV_CLR, int'(clr_v), cyc});
         if (bus.door_open === 1'b1) door_len++;
         else if (door_len > 0) begin obs_q.push_back(ev_t'{EV_DOOR, door_len, cyc}); door_len = 0; end
         if (rst_n && ((bus.moving_up && bus.moving_down) ||
                       (bus.door_open && (bus.moving_up || bus.moving_down)) ||
                       ((clr_v != '0) && (bus.moving_up || bus.moving_down || bus.door_open))))
            inv_bad = 1'b1;
      end
   end

   task automatic push_trip(input int b, input int from, input int to, output int t_end);
      int k, step;
      logic [0:NF-1] oh;
      k    = (to > from) ? to - from : from - to;
      step = (to > from) ? 1 : -1;
      for (int i = 1; i <= k; i++) exp_q.push_back(ev_t'{EV_LOC, from + step * i, b + TRAVEL * i});
      if (k > 0) exp_q.push_back(ev_t'{(to > from) ? EV_UP : EV_DOWN, TRAVEL * k, b + TRAVEL * k});
      oh = '0;
      oh[to - 1] = 1'b1;
      exp_q.push_back(ev_t'{EV_CLR, int'(oh), b + TRAVEL * k});
      t_end = b + TRAVEL * k + DOOR + 1;
      exp_q.push_back(ev_t'{EV_DOOR, DOOR, t_end});
   endtask

   task automatic wait_idle(input int max_cyc, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      bus.target = '0;
      bus.target_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.location !== 4'd1 || bus.busy !== 1'b0 || bus.door_open !== 1'b0 ||
          bus.clear_req !== '0 || bus.moving_up !== 1'b0 || bus.moving_down !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got loc=%0d busy=%b door=%b clr=%b up=%b dn=%b expected loc=1 all others 0",
                  bus.location, bus.busy, bus.door_open, bus.clear_req, bus.moving_up, bus.moving_down);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      obs_q.delete();
      model_loc = 1;
      $display("reset: loc=%0d busy=%b", bus.location, bus.busy);
   endtask

   task automatic test_trip(input string name, input int to);
      int b, t_end;
      bit ok;
      ev_t e, o;
      @(negedge clk);
      bus.target = FLOOR_W'(to);
      bus.target_valid = 1'b1;
      b = cyc + 1;
      push_trip(b, model_loc, to, t_end);
      @(negedge clk);
      bus.target_valid = 1'b0;
      wait_idle(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL %s_timeout got busy=%b expected 0", name, bus.busy); end
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL %s_event got none expected kind=%0d val=%0h t=%0d", name, e.kind, e.val, e.t);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.val !== e.val || o.t !== e.t) begin
               failures++;
               $display("FAIL %s_event got kind=%0d val=%0h t=%0d expected kind=%0d val=%0h t=%0d",
                        name, o.kind, o.val, o.t, e.kind, e.val, e.t);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL %s_extra_events got %0d expected 0", name, obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (bus.location !== FLOOR_W'(to) || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_final got loc=%0d busy=%b expected loc=%0d busy=0", name, bus.location, bus.busy, to);
      end
      $display("trip %s: %0d -> %0d requested at cycle %0d, idle at %0d", name, model_loc, to, b, t_end);
      model_loc = to;
   endtask

   task automatic test_out_of_range();
      int vals[3] = '{0, 11, 15};
      foreach (vals[i]) begin
         @(negedge clk);
         bus.target = FLOOR_W'(vals[i]);
         bus.target_valid = 1'b1;
         @(negedge clk);
         bus.target_valid = 1'b0;
         repeat (4) @(negedge clk);
         #1;
         checks++;
         if (bus.busy !== 1'b0 || bus.location !== FLOOR_W'(model_loc) || obs_q.size() != 0) begin
            failures++;
            $display("FAIL out_of_range_%0d got busy=%b loc=%0d events=%0d expected busy=0 loc=%0d events=0",
                     vals[i], bus.busy, bus.location, obs_q.size(), model_loc);
            obs_q.delete();
         end
         $display("out-of-range target %0d: loc=%0d busy=%b", vals[i], bus.location, bus.busy);
      end
   endtask

   task automatic test_retarget();
      int b, t_end;
      bit ok;
      ev_t e, o;
      @(negedge clk);
      bus.target = FLOOR_W'(6);
      bus.target_valid = 1'b1;
      b = cyc + 1;
      push_trip(b, model_loc, 6, t_end);
      repeat (11) @(negedge clk);
      bus.target = FLOOR_W'(3);
      @(negedge clk);
      bus.target_valid = 1'b0;
      wait_idle(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL retarget_timeout got busy=%b expected 0", bus.busy); end
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL retarget_event got none expected kind=%0d val=%0h t=%0d", e.kind, e.val, e.t);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.val !== e.val || o.t !== e.t) begin
               failures++;
               $display("FAIL retarget_event got kind=%0d val=%0h t=%0d expected kind=%0d val=%0h t=%0d",
                        o.kind, o.val, o.t, e.kind, e.val, e.t);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL retarget_extra_events got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
      $display("retarget: 1 -> 6 with target switched to 3 mid-trip, loc=%0d", bus.location);
      model_loc = 6;
   endtask

   task automatic test_back_to_back();
      int b1, b2, t1, t2;
      bit ok;
      ev_t e, o;
      @(negedge clk);
      bus.target = FLOOR_W'(10);
      bus.target_valid = 1'b1;
      b1 = cyc + 1;
      push_trip(b1, model_loc, 10, t1);
      b2 = t1 + 1;
      push_trip(b2, 10, 8, t2);
      @(negedge clk);
      bus.target = FLOOR_W'(8);
      for (int i = 0; i < 400 && cyc < b2; i++) @(negedge clk);
      bus.target_valid = 1'b0;
      wait_idle(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL back_to_back_timeout got busy=%b expected 0", bus.busy); end
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL back_to_back_event got none expected kind=%0d val=%0h t=%0d", e.kind, e.val, e.t);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.val !== e.val || o.t !== e.t) begin
               failures++;
               $display("FAIL back_to_back_event got kind=%0d val=%0h t=%0d expected kind=%0d val=%0h t=%0d",
                        o.kind, o.val, o.t, e.kind, e.val, e.t);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL back_to_back_extra_events got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
      $display("back-to-back: 6 -> 10 then 10 -> 8, second trip started at cycle %0d", b2);
      model_loc = 8;
   endtask

   task automatic test_mid_move_reset();
      bit seen5, clr_seen;
      @(negedge clk);
      bus.target = FLOOR_W'(3);
      bus.target_valid = 1'b1;
      @(negedge clk);
      bus.target_valid = 1'b0;
      seen5 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.location === 4'd5) begin seen5 = 1'b1; break; end
      end
      checks++;
      if (!seen5) begin failures++; $display("FAIL mid_reset_reach5 got loc=%0d expected 5", bus.location); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.location !== 4'd1 || bus.busy !== 1'b0 || bus.moving_down !== 1'b0 || bus.clear_req !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs got loc=%0d busy=%b dn=%b clr=%b expected loc=1 busy=0 dn=0 clr=0",
                  bus.location, bus.busy, bus.moving_down, bus.clear_req);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      clr_seen = 1'b0;
      foreach (obs_q[i]) if (obs_q[i].kind == EV_CLR) clr_seen = 1'b1;
      obs_q.delete();
      checks++;
      if (clr_seen || bus.location !== 4'd1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_after got clr_pulse=%b loc=%0d busy=%b expected clr_pulse=0 loc=1 busy=0",
                  clr_seen, bus.location, bus.busy);
      end
      $display("mid-move reset at floor 5: loc=%0d busy=%b", bus.location, bus.busy);
      model_loc = 1;
   endtask

`ifdef ELEVATOR_ESTOP_EN
   task automatic test_estop();
      int b;
      bit ok;
      ev_t e, o;
      logic [0:NF-1] oh;
      @(negedge clk);
      bus.target = FLOOR_W'(3);
      bus.target_valid = 1'b1;
      b = cyc + 1;
      oh = '0;
      oh[2] = 1'b1;
      exp_q.push_back(ev_t'{EV_UP, 4, b + 4});
      exp_q.push_back(ev_t'{EV_LOC, 2, b + 13});
      exp_q.push_back(ev_t'{EV_LOC, 3, b + 21});
      exp_q.push_back(ev_t'{EV_UP, 12, b + 21});
      exp_q.push_back(ev_t'{EV_CLR, int'(oh), b + 21});
      exp_q.push_back(ev_t'{EV_DOOR, DOOR, b + 38});
      @(negedge clk);
      bus.target_valid = 1'b0;
      repeat (3) @(negedge clk);
      estop = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.moving_up !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL estop_stall got up=%b busy=%b expected up=0 busy=1", bus.moving_up, bus.busy);
      end
      repeat (3) @(negedge clk);
      estop = 1'b0;
      wait_idle(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL estop_timeout got busy=%b expected 0", bus.busy); end
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL estop_event got none expected kind=%0d val=%0h t=%0d", e.kind, e.val, e.t);
         end else begin
            o = obs_q.pop_front();
            if (o.kind !== e.kind || o.val !== e.val || o.t !== e.t) begin
               failures++;
               $display("FAIL estop_event got kind=%0d val=%0h t=%0d expected kind=%0d val=%0h t=%0d",
                        o.kind, o.val, o.t, e.kind, e.val, e.t);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL estop_extra_events got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
      $display("estop trip 1 -> 3 with 5-cycle stall: loc=%0d", bus.location);
      model_loc = 3;
   endtask
`endif

   task automatic test_invariants();
      checks++;
      if (inv_bad) begin
         failures++;
         $display("FAIL invariants got violation=1 expected 0");
      end
   endtask

   initial begin
      test_reset();
      test_trip("up_1_4", 4);
      test_trip("up_4_7", 7);
      test_trip("same_7", 7);
      test_trip("down_7_2", 2);
      test_trip("down_2_1", 1);
      test_out_of_range();
      test_retarget();
      test_back_to_back();
      test_mid_move_reset();
`ifdef ELEVATOR_ESTOP_EN
      test_estop();
`endif
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
- Consumes the closest-floor selection and moves the elevator car one floor at a time toward it.
- Owns the authoritative car `location`, which feeds back into the floor calculator.
- Times the door dwell at the arrival floor.
- Emits a one-cycle `clear_req` pulse so the request register drops the serviced floor. This closes the request -> select -> move -> clear loop.

Parameters:
- NUM_FLOORS, 10, number of served floors; floors are numbered 1..NUM_FLOORS.
- TRAVEL_CYCLES, 8, clock cycles to travel one floor; must be >= 1.
- DOOR_CYCLES, 16, clock cycles `door_open` stays high at each stop; must be >= 1.
- HOME_FLOOR, 1, car location after reset.

Ports:
- clk, in, 1, system clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- target, in, 4, requested floor from the closest-floor calculator; valid range 1..NUM_FLOORS.
- target_valid, in, 1, high when at least one request is pending.
- location, out, 4, current car floor.
- moving_up, out, 1, car travelling upward.
- moving_down, out, 1, car travelling downward.
- door_open, out, 1, door open.
- clear_req, out, [0:NUM_FLOORS-1], one-hot pulse; bit (location-1) clears that floor's request.
- busy, out, 1, high in any state except IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, location=HOME_FLOOR.
  - moving_up=0, moving_down=0, door_open=0, clear_req=0, busy=0.
  - Travel and door counters = 0.
  - A reset mid-operation abandons the trip immediately; no clear pulse is issued.
- All other outputs are registered and change only on the clk rising edge.
- States: IDLE, MOVING, ARRIVE, DOOR_OPEN.
- IDLE:
  - target is sampled only here, and only when target_valid=1 and 1 <= target <= NUM_FLOORS. Out-of-range targets (0, or > NUM_FLOORS) are ignored; state stays IDLE.
  - If target == location: go to ARRIVE next cycle.
  - Otherwise: latch dest=target and dir=(target>location), load the travel counter with TRAVEL_CYCLES-1, go to MOVING.
- MOVING:
  - moving_up = dir, moving_down = !dir, busy=1. The counter decrements each cycle.
  - On the cycle the counter reaches 0, location steps by +1 or -1.
  - If the new location == dest, go to ARRIVE; otherwise reload the counter and stay in MOVING.
  - A k-floor trip therefore spends exactly k*TRAVEL_CYCLES cycles in MOVING.
  - target and target_valid are ignored while MOVING; dest is latched for the whole trip.
- ARRIVE:
  - Lasts exactly one cycle; moving_* = 0.
  - clear_req has exactly one bit set, bit (location-1).
  - Load the door counter with DOOR_CYCLES-1, then go to DOOR_OPEN.
- DOOR_OPEN:
  - door_open=1 for exactly DOOR_CYCLES cycles, then return to IDLE with door_open=0.
  - The next target can be sampled on the first IDLE cycle.
- Invariants:
  - location is clamped to 1..NUM_FLOORS and never wraps.
  - moving_up and moving_down are never high together.
  - door_open is never high while either moving_* is high.
  - clear_req is zero outside ARRIVE.

Optional Feature:
- Macro: ELEVATOR_ESTOP_EN.
- With the macro defined:
  - An extra input port `estop` (1 bit) is added.
  - estop=1 in MOVING freezes the travel counter and location and drops moving_up/moving_down to 0. state and dest are held.
  - When estop deasserts, the trip resumes from the frozen count.
  - estop in IDLE blocks target sampling.
  - estop in DOOR_OPEN holds the door open and freezes the door counter.
- Without the macro: no `estop` port and no stall logic.

Decomposition:
- Shared package/header `elevator_pkg` holds:
  - FLOOR_W = 4.
  - NUM_FLOORS default.
  - The state encodings IDLE/MOVING/ARRIVE/DOOR_OPEN.
  - A floor-to-one-hot helper function, shared with the request register.
- One sub-module, `elevator_dwell_timer`: a loadable down-counter with load, enable and done outputs.
  - Instantiated twice: once for travel and once for the door.

Test Plan:
1. Reset with rst_n low mid-clock -> outputs update immediately: location=1, busy=0, door_open=0, clear_req=0.
2. From location 1, target=4 with target_valid=1 (TRAVEL 8, DOOR 16):
   - moving_up=1 for 24 cycles; location becomes 2, 3, 4 at +8, +16, +24.
   - Then clear_req=0001000000 for one cycle, then door_open for 16 cycles, then busy=0.
3. From location 7, target=7 -> next cycle clear_req bit6 pulses; door_open=1 for 16 cycles; moving_* remain 0 throughout.
4. target=0, then target=11, each with valid=1 -> state stays IDLE, location unchanged, clear_req stays 0.
5. Retarget and mid-move reset:
   - From location 1, target=6; switch target to 3 at +10 -> car still stops at 6, clear_req bit5 pulses.
   - Separately, assert rst_n low at location 5 -> location=1 immediately, no pulse.
6. ELEVATOR_ESTOP_EN build, 1->3 trip:
   - estop high for 5 cycles starting at +4 -> moving_up low during the stall.
   - location reaches 2 at +13 and 3 at +21, instead of +8 and +16.
